// File: rtl/regfile_pkg.sv
// Shared constants for the register file.
//   DATA_W_DEF : default register width in bits
//   ADDR_W_DEF : default register index width
//   REG_COUNT  : number of registers at the default index width
//   ZERO_IDX   : index of the hard-wired zero register
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_COUNT  = 2 ** ADDR_W_DEF;
  localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Decodes the read index into the storage array, forces index 0 to read
// zero and, when REGFILE_BYPASS_EN is defined, forwards the write data of
// the current cycle when the write targets the same index.
// Ports:
//   i_regs  : full storage array from the top (read only)
//   i_rnum  : read index
//   i_rst_n : active-low reset (forwarding disabled while in reset)
//   i_wen   : write enable of the current cycle
//   i_wnum  : write index of the current cycle
//   i_wd    : write data of the current cycle
//   o_rd    : read data
// Configuration macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] i_rnum,
  input  logic              i_rst_n,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_wnum,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd
);

  localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_IDX);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;

  // Forward only a write that will actually land: not in reset, not to x0.
  assign w_fwd = i_rst_n && i_wen && (i_wnum != W_ZERO) && (i_wnum == i_rnum);

  always_comb begin
    o_rd = i_regs[i_rnum];
    if (i_rnum == W_ZERO) begin
      o_rd = '0;
    end else if (w_fwd) begin
      o_rd = i_wd;
    end
  end
`else
  // Without forwarding the write-side inputs have no effect on this port.
  logic w_unused;
  assign w_unused = ^{i_rst_n, i_wen, i_wnum, i_wd};

  always_comb begin
    o_rd = i_regs[i_rnum];
    if (i_rnum == W_ZERO) begin
      o_rd = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with a hard-wired zero register.
// Storage and write logic live here; each read port is a regfile_rd_port.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset, clears every register
//   Rnum1 : read port 1 index      Rd1 : read port 1 data
//   Rnum2 : read port 2 index      Rd2 : read port 2 data
//   Wen   : write enable
//   Wnum  : write index (writes to index 0 are discarded)
//   Wd    : write data
// Configuration macro: REGFILE_BYPASS_EN enables write-to-read forwarding
// in the read ports; undefined, a same-cycle read returns the old value.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Rnum1,
  input  logic [ADDR_W-1:0] Rnum2,
  output logic [DATA_W-1:0] Rd1,
  output logic [DATA_W-1:0] Rd2,
  input  logic              Wen,
  input  logic [ADDR_W-1:0] Wnum,
  input  logic [DATA_W-1:0] Wd
);

  localparam int              NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Reset has priority over a write in the same cycle. Entry 0 is kept in
  // the array for simple indexing but is never written and masked on read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (Wen && (Wnum != W_ZERO)) begin
      r_regs[Wnum] <= Wd;
    end
  end

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .i_regs  (r_regs),
    .i_rnum  (Rnum1),
    .i_rst_n (rst_n),
    .i_wen   (Wen),
    .i_wnum  (Wnum),
    .i_wd    (Wd),
    .o_rd    (Rd1)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .i_regs  (r_regs),
    .i_rnum  (Rnum2),
    .i_rst_n (rst_n),
    .i_wen   (Wen),
    .i_wnum  (Wnum),
    .i_wd    (Wd),
    .o_rd    (Rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: behavioural array model with a per-cycle
// compare process, directed scenarios and randomized traffic.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] Rnum1, Rnum2, Wnum;
  logic [DW-1:0] Rd1, Rd2, Wd;
  logic          Wen;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] model [NR];
  bit            model_ok = 1'b0;

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Rnum1 (Rnum1),
    .Rnum2 (Rnum2),
    .Rd1   (Rd1),
    .Rd2   (Rd2),
    .Wen   (Wen),
    .Wnum  (Wnum),
    .Wd    (Wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reset clears everything, otherwise a write to a
  // nonzero index stores the data.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
      model_ok = 1'b1;
    end else if (Wen && Wnum != 0) begin
      model[Wnum] = Wd;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (BYP && rst_n && Wen && Wnum != 0 && Wnum == idx) return Wd;
    return model[idx];
  endfunction

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      n_vec++;
      if (Rd1 !== exp_rd(Rnum1)) begin
        n_err++;
        $display("FAIL cyc_rd1 idx=%0d got %h expected %h", Rnum1, Rd1, exp_rd(Rnum1));
      end
      n_vec++;
      if (Rd2 !== exp_rd(Rnum2)) begin
        n_err++;
        $display("FAIL cyc_rd2 idx=%0d got %h expected %h", Rnum2, Rd2, exp_rd(Rnum2));
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 1; i < NR; i++) begin
      Wen = 1'b1; Wnum = AW'(i); Wd = DW'(i);
      tick();
    end
    Wen = 1'b0;
  endtask

  task automatic sweep(input string name, input bit zero);
    Wen = 1'b0;
    for (int i = 0; i < NR; i++) begin
      Rnum1 = AW'(i); Rnum2 = AW'(NR - 1 - i);
      #1;
      chk({name, "_rd1"}, Rd1, zero ? '0 : DW'(i));
      chk({name, "_rd2"}, Rd2, zero ? '0 : DW'(NR - 1 - i));
    end
  endtask

  initial begin
    rst_n = 1'b0; Wen = 1'b0; Wnum = '0; Wd = '0; Rnum1 = '0; Rnum2 = '0;
    // Register 0 reads zero even before any reset edge.
    #1;
    chk("x0_prereset", Rd1, 32'h0);
    tick();
    rst_n = 1'b1;
    sweep("after_reset", 1'b1);

    // Fill every index with its own number.
    fill();
    Rnum1 = 5'd5; Rnum2 = 5'd31; #1;
    chk("fill_r5", Rd1, 32'd5);
    chk("fill_r31", Rd2, 32'd31);

    // Every pair of read indices.
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NR; j++) begin
        Rnum1 = AW'(i); Rnum2 = AW'(j);
        #1;
        chk("pair_rd1", Rd1, DW'(i));
        chk("pair_rd2", Rd2, DW'(j));
      end
    end

    // Write to x0 is discarded.
    Rnum1 = '0; Wen = 1'b1; Wnum = '0; Wd = 32'hFFFF_FFFF;
    tick();
    Wen = 1'b0; #1;
    chk("x0_write", Rd1, 32'h0);

    // Hold: Wen low with random index/data changes nothing.
    for (int k = 0; k < 10; k++) begin
      Wen = 1'b0; Wnum = AW'($urandom); Wd = $urandom;
      tick();
    end
    sweep("hold", 1'b0);

    // Same-cycle read and write of index 7.
    Wen = 1'b1; Wnum = 5'd7; Wd = 32'd7; tick();
    Rnum1 = 5'd7; Wen = 1'b1; Wnum = 5'd7; Wd = 32'd20; #1;
    chk("rw_before_edge", Rd1, BYP ? 32'd20 : 32'd7);
    tick();
    Wen = 1'b0; #1;
    chk("rw_after_edge", Rd1, 32'd20);

    // Randomized traffic, often reading the index being written.
    for (int k = 0; k < 400; k++) begin
      Wen   = ($urandom_range(0, 2) != 0);
      Wnum  = AW'($urandom);
      Wd    = $urandom;
      Rnum1 = ($urandom_range(0, 3) == 0) ? Wnum : AW'($urandom);
      Rnum2 = ($urandom_range(0, 3) == 0) ? Wnum : AW'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;

    // Reset overrides a simultaneous write.
    fill();
    rst_n = 1'b0; Wen = 1'b1; Wnum = 5'd3; Wd = 32'd9;
    tick();
    rst_n = 1'b1; Wen = 1'b0;
    Rnum1 = 5'd3; #1;
    chk("reset_over_write", Rd1, 32'h0);
    sweep("reset_clear", 1'b1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
